tile_dispatcher: RTL and testbench
==================================

# tile_dispatcher

Producer-side companion to the tile accumulator. It holds up to MAX_INPUT_TILES activation tiles of 16 lanes each in a local buffer. On `start` it streams `num_tiles` of them to the accumulator, one tile per cycle, with `act_load` high. It then waits for the accumulator's `ready` and reports completion to the controller.

## Interface
Parameters:
- WIDTH, 16, bits per activation lane
- MAX_INPUT_TILES, 4, buffer depth in tiles
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with the timeout macro

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write one tile into the buffer
- wr_addr  in  $clog2(MAX_INPUT_TILES)  buffer slot to write
- wr_data  in  WIDTH x [15:0]  tile data, 16 lanes
- start  in  1  begin dispatch; sampled in IDLE only
- num_tiles  in  4  tile count for this dispatch; sampled with start
- busy  out  1  high from the cycle after an accepted start until done/err
- done  out  1  one-cycle pulse: accumulator reported ready
- err  out  1  one-cycle pulse: rejected start or timeout
- act_load  out  1  to accumulator: tile valid this cycle
- num_input_tiles  out  4  to accumulator: tile count, held while busy
- activation_input  out  WIDTH x [15:0]  to accumulator: current tile lanes
- acc_ready  in  1  from accumulator: accumulation complete

## Operation
- FSM states: IDLE, LOAD, WAIT.
- IDLE
  - `wr_en` writes `wr_data` into slot `wr_addr`.
  - `start` with 1 ≤ `num_tiles` ≤ MAX_INPUT_TILES: latch the count, clear the tile index, go to LOAD.
  - `start` with `num_tiles` = 0 or > MAX_INPUT_TILES: pulse `err` the next cycle and stay in IDLE.
- LOAD
  - `act_load` = 1; `activation_input` = buffer[index]; index increments each cycle.
  - After tile `num_tiles`-1 is presented, go to WAIT.
- WAIT
  - `act_load` = 0; `activation_input` = 0.
  - On `acc_ready` = 1: pulse `done`, deassert `busy`, return to IDLE.
- `acc_ready` is ignored in IDLE and LOAD.
- `wr_en` while busy is ignored; the buffer is locked during dispatch.
- `start` while busy is ignored; no err.
- Buffer contents persist across dispatches. The buffer is not cleared by reset: contents are X until written.

## Timing
- Reset values: busy, done, err, act_load = 0; num_input_tiles = 0; activation_input all lanes 0; FSM = IDLE; index = 0.
- Reset asserted mid-dispatch: all outputs go to reset values immediately (asynchronous) and the dispatch is abandoned; no done or err.
- Start accepted at edge 0:
  - busy = 1 and num_input_tiles = N from cycle 1.
  - act_load = 1 in cycles 1..N, carrying tile k-1 in cycle k.
  - cycle N+1 onward: act_load = 0.
- `acc_ready` high in cycle c ≥ N+1: done = 1 in cycle c+1, busy = 0 in cycle c+1, num_input_tiles = 0 in cycle c+1. A new start is accepted in cycle c+1.
- Minimum start-to-done latency is N+2 cycles.
- A write in the same cycle as an accepted start takes effect; that tile is dispatched with the new data.

## Configuration
- Macro TILE_DISPATCH_TIMEOUT_EN.
  - Defined: a cycle counter runs in WAIT. If `acc_ready` has not arrived after TIMEOUT_CYCLES cycles in WAIT, err pulses, busy drops, and the FSM returns to IDLE without done.
  - Not defined: no counter; WAIT lasts indefinitely, and err comes only from a rejected start.

## Structure
- Shared package nnoc_pkg holds:
  - LANES = 16
  - typedef for a tile (WIDTH x LANES array)
  - FSM state enum {IDLE, LOAD, WAIT}
- Sub-module tile_buffer: MAX_INPUT_TILES-deep register file with one write port and one combinational read port. Reset does not clear it.

## Test plan
- Write tiles 0..3 with lane values 0x0100+slot; start num_tiles=4 -> act_load high for cycles 1–4 with lanes 0x0100..0x0103 in order, num_input_tiles=4; acc_ready at cycle 8 -> done at cycle 9.
- start num_tiles=0, then num_tiles=5 -> err pulses one cycle after each; busy, act_load stay 0.
- num_tiles=1 with acc_ready held high throughout -> act_load at cycle 1 only; done at cycle 3; acc_ready during LOAD has no effect.
- wr_en to slot 2 with 0xBEEF while busy -> next dispatch still presents the old slot-2 data; start during busy gives no err and no restart.
- Reset pulled low during LOAD cycle 2 of a 4-tile dispatch -> act_load, busy, num_input_tiles go 0 immediately; after release, FSM is in IDLE; no done.
- With TILE_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, no acc_ready -> err pulses after 8 WAIT cycles and busy drops; without the macro, busy stays high for 100 cycles.

Source files
------------

// File: rtl/nnoc_pkg.sv
// rtl/nnoc_pkg.sv - shared lane count, tile type and dispatcher FSM states
package nnoc_pkg;

  localparam int LANES     = 16;
  localparam int DEF_WIDTH = 16;

  typedef logic [LANES-1:0][DEF_WIDTH-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } disp_state_e;

endpackage

// File: rtl/tile_dispatcher_if.sv
// rtl/tile_dispatcher_if.sv - controller/accumulator-facing signals of the tile dispatcher
interface tile_dispatcher_if
  import nnoc_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int MAX_INPUT_TILES = 4
) ();

  localparam int AW = $clog2(MAX_INPUT_TILES);

  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [LANES-1:0][WIDTH-1:0] wr_data;
  logic                        start;
  logic [3:0]                  num_tiles;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic                        act_load;
  logic [3:0]                  num_input_tiles;
  logic [LANES-1:0][WIDTH-1:0] activation_input;
  logic                        acc_ready;

  modport master (
    output wr_en, wr_addr, wr_data, start, num_tiles, acc_ready,
    input  busy, done, err, act_load, num_input_tiles, activation_input
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, num_tiles, acc_ready,
    output busy, done, err, act_load, num_input_tiles, activation_input
  );

endinterface

// File: rtl/tile_buffer.sv
// rtl/tile_buffer.sv - tile register file, one write port, one combinational read port, no reset
module tile_buffer
  import nnoc_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [LANES-1:0][WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [LANES-1:0][WIDTH-1:0] rdata_o
);

  logic [LANES-1:0][WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tile_dispatcher.sv
// rtl/tile_dispatcher.sv - streams buffered tiles to the accumulator and reports completion
// Optional WAIT watchdog: define TILE_DISPATCH_TIMEOUT_EN.
module tile_dispatcher
  import nnoc_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int MAX_INPUT_TILES = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic               clk,
  input logic               reset,
  tile_dispatcher_if.slave  bus
);

  localparam int AW = $clog2(MAX_INPUT_TILES);

  // The tile count port is 4 bits wide, so deeper buffers cannot be addressed.
  if (MAX_INPUT_TILES < 2 || MAX_INPUT_TILES > 15 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("tile_dispatcher: unsupported parameter set");
  end

  disp_state_e                 state_q, state_d;
  logic [3:0]                  idx_q, idx_d;
  logic [3:0]                  count_q, count_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        in_idle;
  logic                        start_ok;
  logic                        tmo_hit;
  logic [LANES-1:0][WIDTH-1:0] rd_tile;

  assign in_idle  = (state_q == IDLE);
  assign start_ok = (bus.num_tiles != 4'd0) &&
                    ({28'd0, bus.num_tiles} <= 32'(MAX_INPUT_TILES));

  tile_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_INPUT_TILES)
  ) u_buf (
    .clk     (clk),
    .we_i    (bus.wr_en && in_idle),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_tile)
  );

`ifdef TILE_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            state_d = LOAD;
            idx_d   = 4'd0;
            count_d = bus.num_tiles;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == count_q - 4'd1) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.acc_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
          count_d = 4'd0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
          count_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      count_q <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // All outputs derive from registers so an asynchronous reset clears them at once.
  assign bus.busy             = !in_idle;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.act_load         = (state_q == LOAD);
  assign bus.num_input_tiles  = count_q;
  assign bus.activation_input = (state_q == LOAD) ? rd_tile : '0;

endmodule

// File: tb/tb_tile_dispatcher.sv
// tb/tb_tile_dispatcher.sv - directed self-checking bench with a tile scoreboard for tile_dispatcher
module tb_tile_dispatcher;
  import nnoc_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  int    vectors     = 0;
  int    miscompares = 0;
  tile_t exp_q[$];
  tile_t shadow[4];

  always #5 clk = ~clk;

  tile_dispatcher_if #(.WIDTH(16), .MAX_INPUT_TILES(4)) bus ();

  tile_dispatcher #(
    .WIDTH           (16),
    .MAX_INPUT_TILES (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic b, input logic a, input logic d, input logic e);
    chk({tag, "_busy"},     256'(bus.busy),     256'(b));
    chk({tag, "_act_load"}, 256'(bus.act_load), 256'(a));
    chk({tag, "_done"},     256'(bus.done),     256'(d));
    chk({tag, "_err"},      256'(bus.err),      256'(e));
  endtask

  function automatic tile_t fill(input logic [15:0] v);
    tile_t t;
    for (int i = 0; i < LANES; i++) t[i] = v;
    return t;
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic push_tiles(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(shadow[k]);
  endtask

  // Scoreboard: every presented tile must match the next expected one.
  always @(negedge clk) begin
    if (bus.act_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tile", 256'(bus.act_load), 256'(0));
      end else begin
        tile_t e;
        e = exp_q.pop_front();
        chk("tile_data", bus.activation_input, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.num_tiles = '0; bus.acc_ready = 1'b0;
    nxt(); nxt();
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_nit", 256'(bus.num_input_tiles), 256'(0));
    chk("rst_act", bus.activation_input, 256'(0));
    rst_n = 1'b1;
    nxt();

    // T1: four tiles, acc_ready in cycle 8
    for (int s = 0; s < 4; s++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 2'(s); bus.wr_data = fill(16'(16'h0100 + s));
      shadow[s] = fill(16'(16'h0100 + s));
      nxt();
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b1; bus.num_tiles = 4'd4; push_tiles(4);
    nxt();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_ctl("t1_load", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_nit", 256'(bus.num_input_tiles), 256'(4));
      nxt();
    end
    for (int c = 5; c <= 7; c++) begin
      chk_ctl("t1_wait", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1_act_zero", bus.activation_input, 256'(0));
      nxt();
    end
    chk_ctl("t1_c8", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.acc_ready = 1'b1;
    nxt();
    bus.acc_ready = 1'b0;
    chk_ctl("t1_done", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_nit_clr", 256'(bus.num_input_tiles), 256'(0));
    nxt();
    chk_ctl("t1_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // T2: rejected starts
    bus.start = 1'b1; bus.num_tiles = 4'd0;
    nxt();
    bus.start = 1'b0;
    chk_ctl("t2_err0", 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();
    chk_ctl("t2_clr0", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.num_tiles = 4'd5;
    nxt();
    bus.start = 1'b0;
    chk_ctl("t2_err5", 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();
    chk_ctl("t2_clr5", 1'b0, 1'b0, 1'b0, 1'b0);

    // T3: single tile, acc_ready held high throughout
    bus.acc_ready = 1'b1; bus.start = 1'b1; bus.num_tiles = 4'd1; push_tiles(1);
    nxt();
    bus.start = 1'b0;
    chk_ctl("t3_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
    chk_ctl("t3_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();
    chk_ctl("t3_c3", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.acc_ready = 1'b0;
    nxt();
    chk_ctl("t3_c4", 1'b0, 1'b0, 1'b0, 1'b0);

    // T4: write and start while busy are ignored
    bus.start = 1'b1; bus.num_tiles = 4'd3; push_tiles(3);
    nxt();
    bus.start = 1'b1; bus.num_tiles = 4'd2;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = fill(16'hBEEF);
    chk_ctl("t4_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    chk_ctl("t4_c2", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
    chk_ctl("t4_c3", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
    chk_ctl("t4_c4", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.acc_ready = 1'b1;
    nxt();
    bus.acc_ready = 1'b0;
    chk_ctl("t4_done", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt();
    chk_ctl("t4_norestart", 1'b0, 1'b0, 1'b0, 1'b0);

    // T4b: write coinciding with accepted start is dispatched
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = fill(16'h3333);
    shadow[3] = fill(16'h3333);
    bus.start = 1'b1; bus.num_tiles = 4'd4; push_tiles(4);
    nxt();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_ctl("t4b_load", 1'b1, 1'b1, 1'b0, 1'b0);
      nxt();
    end
    bus.acc_ready = 1'b1;
    nxt();
    bus.acc_ready = 1'b0;
    chk_ctl("t4b_done", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt();

    // T5: asynchronous reset in LOAD cycle 2
    bus.start = 1'b1; bus.num_tiles = 4'd4; push_tiles(4);
    nxt();
    bus.start = 1'b0;
    chk_ctl("t5_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
    chk_ctl("t5_c2", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_rst_nit", 256'(bus.num_input_tiles), 256'(0));
    chk("t5_rst_act", bus.activation_input, 256'(0));
    exp_q.delete();
    nxt(); nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk_ctl("t5_post", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.acc_ready = 1'b1; bus.start = 1'b1; bus.num_tiles = 4'd1; push_tiles(1);
    nxt();
    bus.start = 1'b0;
    chk_ctl("t5b_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
    chk_ctl("t5b_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();
    chk_ctl("t5b_c3", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.acc_ready = 1'b0;
    nxt();

    // T6: no acc_ready in WAIT
    bus.start = 1'b1; bus.num_tiles = 4'd1; push_tiles(1);
    nxt();
    bus.start = 1'b0;
    chk_ctl("t6_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt();
`ifdef TILE_DISPATCH_TIMEOUT_EN
    for (int c = 2; c <= 9; c++) begin
      chk_ctl("t6_wait", 1'b1, 1'b0, 1'b0, 1'b0);
      nxt();
    end
    chk_ctl("t6_tmo", 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();
    chk_ctl("t6_after", 1'b0, 1'b0, 1'b0, 1'b0);
`else
    for (int c = 0; c < 100; c++) begin
      chk_ctl("t6_hold", 1'b1, 1'b0, 1'b0, 1'b0);
      nxt();
    end
    bus.acc_ready = 1'b1;
    nxt();
    bus.acc_ready = 1'b0;
    chk_ctl("t6_done", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    chk("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
